// File: rtl/div_sequencer_pkg.sv
// Shared types for the DIV sequencer: the core ALU op encoding, the flag index it
// consumes, and the sequencer state enum.
package div_sequencer_pkg;

  localparam int unsigned MC_ALUOp_t_BITS = 5;
  localparam int unsigned CF_IDX          = 0;

  typedef enum logic [MC_ALUOp_t_BITS-1:0] {
    ALUOp_SELA = 5'd0,
    ALUOp_SELB = 5'd1,
    ALUOp_ADD  = 5'd2,
    ALUOp_ADC  = 5'd3,
    ALUOp_SUB  = 5'd4,
    ALUOp_SBB  = 5'd5,
    ALUOp_AND  = 5'd6,
    ALUOp_OR   = 5'd7,
    ALUOp_XOR  = 5'd8,
    ALUOp_NOT  = 5'd9
  } MC_ALUOp_t;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_CHECK,
    DIV_ITER,
    DIV_DONE
  } div_state_t;

endpackage

// File: rtl/div_sequencer_iter_step.sv
// One restoring-division step: choose the ALU difference or the shifted remainder,
// and shift the accept bit into the quotient register.
module div_iter_step
  import div_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] s,
  input  logic             t,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             cf,
  input  logic [WIDTH-2:0] q,
  input  logic             is_8_bit,
  output logic [WIDTH-1:0] p_next,
  output logic [WIDTH-1:0] q_next
);

  localparam int unsigned HALF = WIDTH / 2;

  logic accept;

  always_comb begin
    // a bit shifted out of P means the true value already exceeds the divisor
    accept = t | ~cf;
    p_next = accept ? alu_out : s;
    if (is_8_bit) begin
      p_next[WIDTH-1:HALF] = '0;
    end
    q_next = {q, accept};
  end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle unsigned DIV controller: borrows the core ALU for a CHECK subtract and
// then one restoring-division SUB per quotient bit, for AX/r8 and DX:AX/r16 forms.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       is_8_bit,
  input  logic [2*WIDTH-1:0]         dividend,
  input  logic [WIDTH-1:0]           divisor,
  input  logic                       flush,
  output logic                       busy,
  output logic                       done,
  output logic                       div_error,
  output logic [WIDTH-1:0]           quotient,
  output logic [WIDTH-1:0]           remainder,
  output logic                       alu_req,
  output logic [WIDTH-1:0]           alu_a,
  output logic [WIDTH-1:0]           alu_b,
  output logic [MC_ALUOp_t_BITS-1:0] alu_op,
  output logic                       alu_is_8_bit,
  input  logic [WIDTH-1:0]           alu_out,
  input  logic [15:0]                alu_flags
);

  localparam int unsigned HALF = WIDTH / 2;
  localparam int unsigned CW   = $clog2(WIDTH + 1);

  div_state_t     state;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dvs;
  logic             is8;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] s;
  logic             t;
  logic [WIDTH-1:0] p_next;
  logic [WIDTH-1:0] q_next;
  logic             cf;
  logic             unused_flags;

  assign cf           = alu_flags[CF_IDX];
  assign unused_flags = ^{alu_flags[15:CF_IDX+1]};

  always_comb begin
    s = '0;
    if (is8) begin
      s[HALF-1:0] = {p[HALF-2:0], q[HALF-1]};
      t           = p[HALF-1];
    end else begin
      s = {p[WIDTH-2:0], q[WIDTH-1]};
      t = p[WIDTH-1];
    end
  end

  div_iter_step #(.WIDTH(WIDTH)) u_step (
    .s        (s),
    .t        (t),
    .alu_out  (alu_out),
    .cf       (cf),
    .q        (q[WIDTH-2:0]),
    .is_8_bit (is8),
    .p_next   (p_next),
    .q_next   (q_next)
  );

  // ALU ownership is decoded from the registered state so the core mux sees it early
  always_comb begin
    alu_req      = 1'b0;
    alu_op       = ALUOp_SELA;
    alu_a        = '0;
    alu_b        = '0;
    alu_is_8_bit = 1'b0;
    if (state == DIV_CHECK || state == DIV_ITER) begin
      alu_req      = 1'b1;
      alu_op       = ALUOp_SUB;
      alu_a        = (state == DIV_CHECK) ? p : s;
      alu_b        = dvs;
      alu_is_8_bit = is8;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= DIV_IDLE;
      p         <= '0;
      q         <= '0;
      dvs       <= '0;
      is8       <= 1'b0;
      count     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_error <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= DIV_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          DIV_IDLE: begin
            if (start) begin
              is8       <= is_8_bit;
              div_error <= 1'b0;
              busy      <= 1'b1;
              state     <= DIV_CHECK;
              if (is_8_bit) begin
                p   <= {{HALF{1'b0}}, dividend[WIDTH-1:HALF]};
                q   <= {{HALF{1'b0}}, dividend[HALF-1:0]};
                dvs <= {{HALF{1'b0}}, divisor[HALF-1:0]};
              end else begin
                p   <= dividend[2*WIDTH-1:WIDTH];
                q   <= dividend[WIDTH-1:0];
                dvs <= divisor;
              end
            end
          end
          DIV_CHECK: begin
            if (!cf) begin
              div_error <= 1'b1;
              done      <= 1'b1;
              state     <= DIV_DONE;
            end else begin
              count <= is8 ? CW'(HALF) : CW'(WIDTH);
              state <= DIV_ITER;
            end
          end
          DIV_ITER: begin
            p     <= p_next;
            q     <= q_next;
            count <= count - CW'(1);
            if (count == CW'(1)) begin
              quotient  <= is8 ? {{HALF{1'b0}}, q_next[HALF-1:0]} : q_next;
              remainder <= p_next;
              done      <= 1'b1;
              state     <= DIV_DONE;
            end
          end
          DIV_DONE: begin
            busy  <= 1'b0;
            state <= DIV_IDLE;
          end
          default: state <= DIV_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: behavioural ALU beside the DUT, directed
// vectors plus randomized operations checked against an arithmetic divide model.
module tb_div_sequencer;
  import div_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        is_8_bit = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        busy, done, div_error, alu_req, alu_is_8_bit;
  logic [15:0] quotient, remainder, alu_a, alu_b, alu_out, alu_flags;
  logic [MC_ALUOp_t_BITS-1:0] alu_op;
  logic        cf_bit;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q = '0;
  logic [15:0] exp_r = '0;
  logic        exp_err = 1'b0;

  always #5 clk = ~clk;

  div_sequencer #(.WIDTH(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .is_8_bit     (is_8_bit),
    .dividend     (dividend),
    .divisor      (divisor),
    .flush        (flush),
    .busy         (busy),
    .done         (done),
    .div_error    (div_error),
    .quotient     (quotient),
    .remainder    (remainder),
    .alu_req      (alu_req),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_is_8_bit (alu_is_8_bit),
    .alu_out      (alu_out),
    .alu_flags    (alu_flags)
  );

  // behavioural core ALU: subtract with borrow flag at the selected width
  always_comb begin
    alu_flags = '0;
    if (alu_is_8_bit) begin
      alu_out = {8'h00, alu_a[7:0] - alu_b[7:0]};
      cf_bit  = (alu_a[7:0] < alu_b[7:0]);
    end else begin
      alu_out = alu_a - alu_b;
      cf_bit  = (alu_a < alu_b);
    end
    alu_flags[CF_IDX] = cf_bit;
  end

  function automatic void ref_div(input logic w8, input logic [31:0] dvd, input logic [15:0] dvs,
                                  output logic err, output logic [15:0] q, output logic [15:0] r);
    logic [31:0] n, d, qq, rr;
    n = w8 ? {16'h0000, dvd[15:0]} : dvd;
    d = w8 ? {24'h000000, dvs[7:0]} : {16'h0000, dvs};
    q = '0;
    r = '0;
    if (d == 0) begin
      err = 1'b1;
    end else begin
      qq  = n / d;
      rr  = n % d;
      err = w8 ? (qq > 32'd255) : (qq > 32'h0000_FFFF);
      q   = qq[15:0];
      r   = rr[15:0];
    end
  endfunction

  // Drives one operation and records what the DUT did over a fixed 30-cycle window.
  task automatic run_op(input logic w8, input logic [31:0] dvd, input logic [15:0] dvs,
                        input bit hold, input int flush_at,
                        output int done_cyc, output int done_cnt, output int busy_cnt,
                        output int req_cnt, output int bad_alu);
    done_cyc = 0; done_cnt = 0; busy_cnt = 0; req_cnt = 0; bad_alu = 0;
    @(posedge clk); #1;
    is_8_bit = w8; dividend = dvd; divisor = dvs; start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      else begin
        dividend = $urandom; divisor = 16'($urandom); is_8_bit = 1'($urandom);
      end
      flush = (c == flush_at);
      if (busy) busy_cnt++;
      if (alu_req) begin
        req_cnt++;
        if (alu_op !== ALUOp_SUB || alu_is_8_bit !== w8) bad_alu++;
      end else if (alu_op !== ALUOp_SELA || alu_a !== 16'h0 || alu_b !== 16'h0) bad_alu++;
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
        start = 1'b0;
      end
    end
    start = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || div_error !== 1'b0 || alu_req !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: busy=%b done=%b err=%b req=%b expected all 0", busy, done, div_error, alu_req);
    end
    checks++; if (quotient !== 16'h0 || remainder !== 16'h0) begin
      errors++; $display("FAIL reset_result: q=%h r=%h expected 0000 0000", quotient, remainder);
    end
    checks++; if (alu_a !== 16'h0 || alu_b !== 16'h0 || alu_op !== ALUOp_SELA) begin
      errors++; $display("FAIL reset_alu: a=%h b=%h op=%0d expected 0 0 SELA", alu_a, alu_b, alu_op);
    end
    @(negedge clk); reset_n = 1'b1;
    exp_q = '0; exp_r = '0; exp_err = 1'b0;
  endtask

  typedef struct {
    logic        w8;
    logic [31:0] dvd;
    logic [15:0] dvs;
    logic [15:0] q;
    logic [15:0] r;
    logic        err;
    int          cyc;
  } vec_t;

  task automatic test_directed();
    vec_t v[5];
    int dc, dn, bc, rc, ba;
    v[0] = '{1'b0, 32'h0001_0000, 16'h0003, 16'h5555, 16'h0001, 1'b0, 18};
    v[1] = '{1'b1, 32'h0000_0064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 10};
    v[2] = '{1'b0, 32'h1234_5678, 16'h0000, 16'h000E, 16'h0002, 1'b1, 2};
    v[3] = '{1'b1, 32'h0000_0700, 16'h0007, 16'h000E, 16'h0002, 1'b1, 2};
    v[4] = '{1'b0, 32'hFFFE_FFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 18};
    for (int i = 0; i < 5; i++) begin
      run_op(v[i].w8, v[i].dvd, v[i].dvs, 1'b0, 0, dc, dn, bc, rc, ba);
      checks++; if (dc !== v[i].cyc || dn !== 1) begin
        errors++; $display("FAIL dir%0d_done: cycle=%0d count=%0d expected cycle=%0d count=1", i, dc, dn, v[i].cyc);
      end
      checks++; if (quotient !== v[i].q || remainder !== v[i].r) begin
        errors++; $display("FAIL dir%0d_result: q=%h r=%h expected q=%h r=%h", i, quotient, remainder, v[i].q, v[i].r);
      end
      checks++; if (div_error !== v[i].err) begin
        errors++; $display("FAIL dir%0d_err: got %b expected %b", i, div_error, v[i].err);
      end
      checks++; if (bc !== v[i].cyc || rc !== v[i].cyc - 1 || ba !== 0) begin
        errors++; $display("FAIL dir%0d_alu: busy_cycles=%0d req_cycles=%0d bad=%0d expected %0d %0d 0", i, bc, rc, ba, v[i].cyc, v[i].cyc - 1);
      end
    end
    exp_q = 16'hFFFF; exp_r = 16'hFFFE; exp_err = 1'b0;
  endtask

  task automatic test_random();
    int dc, dn, bc, rc, ba, want_cyc;
    logic w8, e;
    logic [31:0] dvd;
    logic [15:0] dvs, q, r;
    for (int i = 0; i < 40; i++) begin
      w8  = 1'($urandom);
      dvd = $urandom;
      dvs = 16'($urandom);
      if ($urandom_range(0, 7) == 0) dvs = '0;
      else if ($urandom_range(0, 3) != 0) begin
        if (w8 && dvs[7:0] != 0) dvd[15:8] = dvd[15:8] % dvs[7:0];
        if (!w8 && dvs != 0) dvd[31:16] = dvd[31:16] % dvs;
      end
      ref_div(w8, dvd, dvs, e, q, r);
      if (e) exp_err = 1'b1;
      else begin exp_q = q; exp_r = r; exp_err = 1'b0; end
      want_cyc = e ? 2 : (w8 ? 10 : 18);
      run_op(w8, dvd, dvs, 1'b0, 0, dc, dn, bc, rc, ba);
      checks++; if (dc !== want_cyc || dn !== 1) begin
        errors++; $display("FAIL rnd%0d_done: cycle=%0d count=%0d expected cycle=%0d count=1", i, dc, dn, want_cyc);
      end
      checks++; if (quotient !== exp_q || remainder !== exp_r || div_error !== exp_err) begin
        errors++; $display("FAIL rnd%0d_result: w8=%b %h/%h q=%h r=%h e=%b expected q=%h r=%h e=%b",
                           i, w8, dvd, dvs, quotient, remainder, div_error, exp_q, exp_r, exp_err);
      end
      checks++; if (ba !== 0) begin
        errors++; $display("FAIL rnd%0d_alu: bad alu cycles=%0d expected 0", i, ba);
      end
    end
  endtask

  task automatic test_back_to_back_start();
    int dc, dn, bc, rc, ba;
    logic e;
    logic [15:0] q, r;
    ref_div(1'b0, 32'h0012_3456, 16'h1234, e, q, r);
    exp_q = q; exp_r = r; exp_err = e;
    run_op(1'b0, 32'h0012_3456, 16'h1234, 1'b1, 0, dc, dn, bc, rc, ba);
    checks++; if (dn !== 1 || dc !== 18) begin
      errors++; $display("FAIL held_start_done: count=%0d cycle=%0d expected count=1 cycle=18", dn, dc);
    end
    checks++; if (quotient !== exp_q || remainder !== exp_r || div_error !== exp_err) begin
      errors++; $display("FAIL held_start_result: q=%h r=%h e=%b expected q=%h r=%h e=%b", quotient, remainder, div_error, exp_q, exp_r, exp_err);
    end
  endtask

  task automatic test_flush();
    int dc, dn, bc, rc, ba;
    run_op(1'b0, 32'h0001_0000, 16'h0007, 1'b0, 5, dc, dn, bc, rc, ba);
    exp_err = 1'b0;
    checks++; if (dn !== 0 || bc !== 5) begin
      errors++; $display("FAIL flush_abort: done_count=%0d busy_cycles=%0d expected 0 5", dn, bc);
    end
    checks++; if (quotient !== exp_q || remainder !== exp_r || div_error !== exp_err) begin
      errors++; $display("FAIL flush_hold: q=%h r=%h e=%b expected q=%h r=%h e=%b", quotient, remainder, div_error, exp_q, exp_r, exp_err);
    end
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; is_8_bit = 1'b0; dividend = 32'h0000_0100; divisor = 16'h0001;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    checks++; if (busy !== 1'b0 || alu_req !== 1'b0) begin
      errors++; $display("FAIL flush_idle_start: busy=%b req=%b expected 0 0", busy, alu_req);
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    is_8_bit = 1'b0; dividend = 32'h0001_0000; divisor = 16'h0003; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || div_error !== 1'b0 || alu_req !== 1'b0) begin
      errors++; $display("FAIL async_reset_ctrl: busy=%b done=%b err=%b req=%b expected all 0", busy, done, div_error, alu_req);
    end
    checks++; if (quotient !== 16'h0 || remainder !== 16'h0 || alu_a !== 16'h0 || alu_b !== 16'h0 || alu_op !== ALUOp_SELA) begin
      errors++; $display("FAIL async_reset_data: q=%h r=%h a=%h b=%h op=%0d expected zeros and SELA", quotient, remainder, alu_a, alu_b, alu_op);
    end
    @(negedge clk); reset_n = 1'b1;
    exp_q = '0; exp_r = '0; exp_err = 1'b0;
  endtask

  task automatic test_after_reset();
    int dc, dn, bc, rc, ba;
    run_op(1'b1, 32'h0000_00FF, 16'h0010, 1'b0, 0, dc, dn, bc, rc, ba);
    checks++; if (dc !== 10 || quotient !== 16'h000F || remainder !== 16'h000F || div_error !== 1'b0) begin
      errors++; $display("FAIL post_reset_op: cycle=%0d q=%h r=%h e=%b expected 10 000F 000F 0", dc, quotient, remainder, div_error);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back_start();
    test_flush();
    test_async_reset();
    test_after_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
